systolic_feeder: RTL and testbench

Operand feeder that drives the A/B inputs of the 4x4 systolic array. It buffers one N×N matrix A and one N×N matrix B, loaded row by row. On `start` it streams both matrices into the array's row lanes (a0..a3) and column lanes (b0..b3) with the diagonal skew the array needs. It sits between the operand load path and the array, and is the producer side of the array's a/b interface.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/systolic_feeder_if.sv | 33 +++
 rtl/systolic_operand_buf.sv | 64 ++++++
 rtl/systolic_feeder.sv | 112 +++++++++++
 tb/tb_systolic_feeder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array operand feeder.
// Used by systolic_feeder, its interface and its operand buffers.
package systolic_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int N_DEF      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } feeder_state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // Index width that stays legal for a degenerate 1-lane array.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Load-path and array-side signal bundle of the systolic operand feeder.
// master = load/array side, slave = the feeder itself.
interface systolic_feeder_if
   import systolic_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N      = N_DEF
);
   localparam int RW = idx_w(N);

   logic              ld_valid;
   logic              ld_ready;
   logic              ld_sel;
   logic [RW-1:0]     ld_row;
   logic [N*DATA_W-1:0] ld_data;
   logic              start;
   logic              busy;
   logic [N*DATA_W-1:0] a_out;
   logic [N*DATA_W-1:0] b_out;
   logic              out_valid;
   logic              done;

   modport master (
      output ld_valid, ld_sel, ld_row, ld_data, start,
      input  ld_ready, busy, a_out, b_out, out_valid, done
   );

   modport slave (
      input  ld_valid, ld_sel, ld_row, ld_data, start,
      output ld_ready, busy, a_out, b_out, out_valid, done
   );

endinterface

// File: rtl/systolic_operand_buf.sv
// N x N operand store with a row write port and a diagonally skewed lane read.
// Reads see the write of the same cycle so a load issued with start is streamed.
module systolic_operand_buf
   import systolic_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N      = N_DEF,
   parameter int TW     = $clog2(4 * N),
   parameter int RW     = idx_w(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [RW-1:0]       wr_row,
   input  logic [N*DATA_W-1:0] wr_data,
   input  logic [TW-1:0]       t,
   input  logic                col_major,
   output logic [N*DATA_W-1:0] lanes
);

   logic [DATA_W-1:0] mem     [N][N];
   logic [DATA_W-1:0] mem_nxt [N][N];

   always_comb begin
      mem_nxt = mem;
      if (wr_en) begin
         for (int j = 0; j < N; j++) begin
            mem_nxt[wr_row][j] = wr_data[j*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               mem[i][j] <= '0;
            end
         end
      end else begin
         mem <= mem_nxt;
      end
   end

   // Lane l carries element (l, t-l) row-major or (t-l, l) column-major.
   always_comb begin
      int            k;
      logic [RW-1:0] idx;
      logic [RW-1:0] lane;
      lanes = '0;
      k     = 0;
      idx   = '0;
      lane  = '0;
      for (int l = 0; l < N; l++) begin
         k    = int'(t) - l;
         idx  = k[RW-1:0];
         lane = l[RW-1:0];
         if (k >= 0 && k < N) begin
            lanes[l*DATA_W +: DATA_W] = col_major ? mem_nxt[idx][lane] : mem_nxt[lane][idx];
         end
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Streams buffered A/B matrices into the systolic array with diagonal skew.
// Define SYSTOLIC_FEEDER_DRAIN_EN to append N all-zero flush beats.
//
// state  | meaning
// IDLE   | loads accepted, waiting for start
// STREAM | skewed beats t = 0 .. 3N-3
// DRAIN  | N zero beats to flush partial sums (drain build only)
// DONE   | one-cycle done pulse, lanes idle
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N      = N_DEF
) (
   input logic               clk,
   input logic               rst,
   systolic_feeder_if.slave  bus
);

   localparam int            TW          = $clog2(4 * N);
   localparam logic [TW-1:0] T_LAST      = TW'(3 * N - 3);
   localparam logic [TW-1:0] T_DRAIN_END = TW'(N - 1);

   feeder_state_t       state, state_nxt;
   logic [TW-1:0]       t, t_nxt;
   logic                ld_acc;
   logic [N*DATA_W-1:0] a_lanes, b_lanes;

   assign ld_acc = bus.ld_valid && (state == IDLE);

   systolic_operand_buf #(.DATA_W(DATA_W), .N(N), .TW(TW)) u_buf_a (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (ld_acc && (bus.ld_sel == SEL_A)),
      .wr_row    (bus.ld_row),
      .wr_data   (bus.ld_data),
      .t         (t_nxt),
      .col_major (1'b0),
      .lanes     (a_lanes)
   );

   systolic_operand_buf #(.DATA_W(DATA_W), .N(N), .TW(TW)) u_buf_b (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (ld_acc && (bus.ld_sel == SEL_B)),
      .wr_row    (bus.ld_row),
      .wr_data   (bus.ld_data),
      .t         (t_nxt),
      .col_major (1'b1),
      .lanes     (b_lanes)
   );

   always_comb begin
      state_nxt = state;
      t_nxt     = t;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = STREAM;
               t_nxt     = '0;
            end
         end
         STREAM: begin
            if (t == T_LAST) begin
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
               state_nxt = DRAIN;
               t_nxt     = '0;
`else
               state_nxt = DONE;
`endif
            end else begin
               t_nxt = t + 1'b1;
            end
         end
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
         DRAIN: begin
            if (t == T_DRAIN_END) begin
               state_nxt = DONE;
            end else begin
               t_nxt = t + 1'b1;
            end
         end
`endif
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so beat t lands t cycles after start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         t             <= '0;
         bus.ld_ready  <= 1'b1;
         bus.busy      <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.done      <= 1'b0;
         bus.a_out     <= '0;
         bus.b_out     <= '0;
      end else begin
         state         <= state_nxt;
         t             <= t_nxt;
         bus.ld_ready  <= (state_nxt == IDLE);
         bus.busy      <= (state_nxt == STREAM) || (state_nxt == DRAIN);
         bus.out_valid <= (state_nxt == STREAM) || (state_nxt == DRAIN);
         bus.done      <= (state_nxt == DONE);
         bus.a_out     <= (state_nxt == STREAM) ? a_lanes : '0;
         bus.b_out     <= (state_nxt == STREAM) ? b_lanes : '0;
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus pushes expected beats,
// a negedge monitor pops and compares every valid beat.
module tb_systolic_feeder;
   import systolic_pkg::*;

   localparam int DW = 64;
   localparam int N  = 4;
   localparam int LW = N * DW;
`ifdef SYSTOLIC_FEEDER_DRAIN_EN
   localparam int DONE_P  = 15;
   localparam int N_DRAIN = N;
`else
   localparam int DONE_P  = 11;
   localparam int N_DRAIN = 0;
`endif

   typedef struct packed {
      logic [LW-1:0] a;
      logic [LW-1:0] b;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   systolic_feeder_if #(.DATA_W(DW), .N(N)) bus ();
   systolic_feeder #(.DATA_W(DW), .N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   beat_t         exp_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] ma [N][N];
   logic [DW-1:0] mb [N][N];
   logic [LW-1:0] cap_a [16];
   logic [LW-1:0] cap_b [16];
   int            beat_idx = 0;

   task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   function automatic logic [LW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
      return {64'(l3), 64'(l2), 64'(l1), 64'(l0)};
   endfunction

   function automatic beat_t model_beat(input int t);
      beat_t r;
      int    k;
      r = '0;
      for (int l = 0; l < N; l++) begin
         k = t - l;
         if (k >= 0 && k < N) begin
            r.a[l*DW +: DW] = ma[l][k];
            r.b[l*DW +: DW] = mb[k][l];
         end
      end
      return r;
   endfunction

   always @(negedge clk) begin
      beat_t e;
      if (bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_beat: got beat %0d required none", beat_idx);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("beat%0d_a", beat_idx), bus.a_out, e.a);
            check($sformatf("beat%0d_b", beat_idx), bus.b_out, e.b);
         end
         if (beat_idx < 16) begin
            cap_a[beat_idx] = bus.a_out;
            cap_b[beat_idx] = bus.b_out;
         end
         beat_idx++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic sel, input int row, input logic [LW-1:0] data);
      bus.ld_valid = 1'b1;
      bus.ld_sel   = sel;
      bus.ld_row   = 2'(row);
      bus.ld_data  = data;
      for (int j = 0; j < N; j++) begin
         if (sel == SEL_A) ma[row][j] = data[j*DW +: DW];
         else              mb[row][j] = data[j*DW +: DW];
      end
      tick();
      bus.ld_valid = 1'b0;
   endtask

   task automatic load_fixture();
      load(SEL_B, 1, pack4(9, 9, 9, 9));
      for (int i = 0; i < N; i++) begin
         load(SEL_A, i, pack4(10*i + 1, 10*i + 2, 10*i + 3, 10*i + 4));
         load(SEL_B, i, pack4(100 + 10*i, 101 + 10*i, 102 + 10*i, 103 + 10*i));
      end
   endtask

   task automatic push_stream();
      for (int t = 0; t <= 3*N - 3; t++) exp_q.push_back(model_beat(t));
      for (int d = 0; d < N_DRAIN; d++) exp_q.push_back('0);
   endtask

   // hook 1: foreign load in period 3; hook 2: extra start in period 4;
   // hook 3: A row 3 reloaded in the start cycle itself.
   task automatic run(input int hook, input string tag);
      int p;
      if (hook == 3) begin
         bus.ld_valid = 1'b1;
         bus.ld_sel   = SEL_A;
         bus.ld_row   = 2'd3;
         bus.ld_data  = pack4(200, 201, 202, 203);
         for (int j = 0; j < N; j++) ma[3][j] = 64'(200 + j);
      end
      push_stream();
      beat_idx  = 0;
      bus.start = 1'b1;
      tick();
      bus.start    = 1'b0;
      bus.ld_valid = 1'b0;
      p = 1;
      while (p <= 40) begin
         if (hook == 1 && p == 3) begin
            bus.ld_valid = 1'b1;
            bus.ld_sel   = SEL_A;
            bus.ld_row   = 2'd0;
            bus.ld_data  = {LW{1'b1}};
         end
         if (hook == 2 && p == 4) bus.start = 1'b1;
         @(negedge clk);
         if (hook == 1 && p == 3) check({tag, "_ld_ready_stream"}, LW'(bus.ld_ready), '0);
         if (bus.done === 1'b1) break;
         tick();
         bus.ld_valid = 1'b0;
         bus.start    = 1'b0;
         p++;
      end
      bus.ld_valid = 1'b0;
      bus.start    = 1'b0;
      check({tag, "_done_period"}, LW'(p), LW'(DONE_P));
      check({tag, "_done_lanes"}, bus.a_out | bus.b_out, '0);
      check({tag, "_done_valid"}, LW'(bus.out_valid), '0);
      check({tag, "_leftover"}, LW'(exp_q.size()), '0);
      tick();
      check({tag, "_idle_ready"}, LW'(bus.ld_ready), LW'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ld_valid = 1'b0;
      bus.ld_sel   = SEL_A;
      bus.ld_row   = '0;
      bus.ld_data  = '0;
      bus.start    = 1'b0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = '0;
            mb[i][j] = '0;
         end
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_ld_ready", LW'(bus.ld_ready), LW'(1));
      check("rst_busy", LW'(bus.busy), '0);
      check("rst_valid_done", LW'({bus.out_valid, bus.done}), '0);
      check("rst_lanes", bus.a_out | bus.b_out, '0);
      tick();

      load_fixture();
      run(0, "basic");
      check("hand_b0_a", cap_a[0], pack4(1, 0, 0, 0));
      check("hand_b0_b", cap_b[0], pack4(100, 0, 0, 0));
      check("hand_b1_a", cap_a[1], pack4(2, 11, 0, 0));
      check("hand_b1_b", cap_b[1], pack4(110, 101, 0, 0));
      check("hand_b6_a", cap_a[6], pack4(0, 0, 0, 34));
      check("hand_b6_b", cap_b[6], pack4(0, 0, 0, 133));
      check("hand_b9_ab", cap_a[9] | cap_b[9], '0);

      run(1, "ld_in_stream");
      run(0, "rerun");
      check("rerun_lane0", cap_a[0], pack4(1, 0, 0, 0));

      run(2, "second_start");

      run(3, "ld_with_start");
      check("hand_b3_a_new", cap_a[3], pack4(4, 13, 22, 200));

      // reset at beat 5, then restart with the cleared buffers
      push_stream();
      beat_idx  = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midrst_lanes", bus.a_out | bus.b_out, '0);
      check("midrst_flags", LW'({bus.busy, bus.out_valid, bus.done}), '0);
      check("midrst_ready", LW'(bus.ld_ready), LW'(1));
      check("midrst_beats_seen", LW'(beat_idx), LW'(6));
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            ma[i][j] = '0;
            mb[i][j] = '0;
         end
      tick();
      run(0, "zero_restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
